// File: rtl/lab1_1_bist_if.sv
// ALU-under-test bus: the BIST drives op/a/b and reads back the combinational result d.
interface lab1_1_bist_if;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;

    modport master (output op, a, b, input d);
    modport slave  (input op, a, b, output d);
endinterface

// File: rtl/lab1_1_bist.sv
// Exhaustive BIST for a 4-bit ALU: sweeps every {op,a,b}, holds each vector SETTLE
// cycles, compares d against the golden result and records error count and first failure.
module lab1_1_bist #(
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    lab1_1_bist_if.master       alu,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [10:0]         err_cnt,
    output logic [9:0]          first_err_vec,
    output logic                first_err_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] WLAST   = 4'(SETTLE - 1);
    localparam logic [9:0] VEC_MAX = 10'd1023;

    state_t     state;
    logic [9:0] vec;
    logic [3:0] wait_cnt;
    logic [3:0] gold;
    logic       cmp_now;
    logic       mis;

    function automatic logic [3:0] golden(input logic [1:0] f_op,
                                          input logic [3:0] f_a,
                                          input logic [3:0] f_b);
        logic [3:0] r;
        case (f_op)
            2'b00:   r = f_a & f_b;
            2'b01:   r = (f_b >= 4'd4) ? 4'b0000 : 4'(f_a << f_b[1:0]);
            2'b10:   r = f_a | f_b;
            default: r = (f_b >= 4'd4) ? 4'b0000 : 4'(f_a >> f_b[1:0]);
        endcase
        return r;
    endfunction

    assign alu.op = vec[9:8];
    assign alu.a  = vec[7:4];
    assign alu.b  = vec[3:0];

    assign gold    = golden(vec[9:8], vec[7:4], vec[3:0]);
    assign cmp_now = (state == RUN) && (wait_cnt == WLAST);
    assign mis     = (alu.d != gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state           <= RUN;
                        vec             <= '0;
                        wait_cnt        <= '0;
                        busy            <= 1'b1;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state           <= IDLE;
                        vec             <= '0;
                        wait_cnt        <= '0;
                        busy            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end else if (cmp_now) begin
                        if (mis) begin
                            err_cnt <= err_cnt + 11'd1;
                            if (!first_err_valid) begin
                                first_err_vec   <= vec;
                                first_err_valid <= 1'b1;
                            end
                        end
                        wait_cnt <= '0;
                        if (vec == VEC_MAX) begin
                            // Final compare: pass must reflect this vector's result too.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == 11'd0) && !mis;
                        end else begin
                            vec <= vec + 10'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (abort || start) begin
                        state           <= abort ? IDLE : RUN;
                        busy            <= !abort;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        vec             <= '0;
                        wait_cnt        <= '0;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end
endmodule
